serial_twos_negator: RTL and testbench
======================================

# serial_twos_negator

Parametrised, multi-lane successor to our single-bit serial two's-complement inverter. Each of CHANNELS lanes takes a LSB-first serial word of WIDTH bits. In negate mode a lane passes bits through up to and including the first 1, then inverts every later bit. In pass mode it forwards bits unchanged. The block adds word framing, per-lane mode select, a registered serial output, a parallel result word, and overflow/zero flags; it sits between the serial datapath front-end and word-level consumers.

## Interface
- WIDTH, 8, bits per word (≥2)
- CHANNELS, 4, independent lanes sharing one framing counter
- t_clk  in  1  clock, rising edge
- r_n  in  1  asynchronous reset, active-low
- bit_valid  in  1  one bit per lane accepted on a rising edge when high
- sof  in  1  qualified by bit_valid; marks the accepted bit as LSB of a new word
- neg  in  CHANNELS  per-lane mode (1 = negate, 0 = pass), sampled only with the LSB
- din  in  CHANNELS  serial data bit per lane
- y  out  CHANNELS  registered serial result bit per lane
- y_valid  out  1  y carries a new bit
- word  out  CHANNELS*WIDTH  lane k result at [k*WIDTH +: WIDTH]
- word_valid  out  1  one-cycle pulse; word/ovf/zero valid
- ovf  out  CHANNELS  negate of most-negative value (result equals input)
- zero  out  CHANNELS  input word was all zeros
- sync_err  out  1  one-cycle pulse; a word was aborted by sof

## Operation
- Shared bit counter `cnt` (0..WIDTH-1); each accepted bit increments it, wrapping WIDTH-1→0; words are implicitly back-to-back, sof optional at cnt=0.
- Accepted bit with sof=1: treated as LSB; cnt forced to position 0; every lane re-arms. If cnt≠0 at that moment, the partial word is discarded (no word_valid) and sync_err pulses.
- Accepted LSB (cnt=0 or sof): each lane latches neg into mode_q and clears its shift register and flags.
- Lane FSM, two states, advancing only on accepted bits:
  - SEEK: y=din; din=1 → FLIP
  - FLIP: y=~din (negate mode); stays FLIP until next LSB
  - Pass mode: y=din; FSM still tracks SEEK/FLIP for flags
- The LSB starts in SEEK regardless of the previous word.
- Result bit shifts into a WIDTH-bit lane register at position cnt.
- zero[k]=1 iff lane k stayed in SEEK through the MSB.
- ovf[k]=1 iff mode_q=negate and the first 1 arrived at the MSB (input = 1 followed by WIDTH-1 zeros).
- bit_valid low: no state changes; y holds; y_valid=0.
- Reset (asynchronous, any time, including mid-word): all outputs 0, lanes SEEK, cnt=0, mode_q=0. The first accepted bit after release is an LSB.

## Timing
- y/y_valid are registered on the edge that accepts the bit and are visible the cycle after acceptance; latency 1 cycle, throughput 1 bit/cycle/lane.
- word_valid/word/ovf/zero are registered on the edge that accepts the MSB, so they coincide with the MSB's y_valid cycle.
- word/ovf/zero hold until the next word completes. word_valid is a 1-cycle pulse.
- sync_err is asserted in the cycle after the aborting sof bit is accepted, aligned with that LSB's y_valid.
- sof at cnt=0 with a just-completed MSB in the prior cycle: legal, no sync_err.
- No backpressure; the consumer must take word within the pulse.

## Structure
- Package neg_pkg:
  - lane_state_t enum {SEEK, FLIP}
  - mode constants NEG_PASS=0, NEG_NEGATE=1
  - cnt width function $clog2(WIDTH)
- Sub-module serial_negate_lane (one per channel via generate): FSM, mode_q, shift register, flags.
- Top: cnt, sof/abort logic, y_valid/word_valid/sync_err, output packing.

## Test plan
- WIDTH=4, CHANNELS=2, lane0 neg=1, din 0,1,1,0 (0110); lane1 neg=0, din 1,1,0,0 (0011) → lane0 y 0,1,0,1 and word[3:0]=1010; lane1 word[7:4]=0011; word_valid one pulse with the MSB y_valid.
- Lane0 negate 1000 (din 0,0,0,1) → word[3:0]=1000, ovf[0]=1, zero[0]=0.
- Lane0 negate 0000 → word 0000, zero[0]=1, ovf[0]=0; next word 0001 → 1111, zero=0.
- Two back-to-back words, no sof after the first, bit_valid low 3 cycles mid-word → two word_valid pulses, correct results (0101→1011, 0111→1001), y_valid low during the gap, y held.
- sof on bit 2 of a word → sync_err pulse, no word_valid for the aborted word; the following 4 bits 0010 negate → 1110.
- r_n low after bit 1 → all outputs 0 immediately; after release, the first bit is treated as LSB and word 0011 negates to 1101.

Source files
------------

// File: rtl/neg_pkg.sv
// Shared types and helpers for the serial two's-complement negator.
package neg_pkg;

  typedef enum logic {
    SEEK = 1'b0,
    FLIP = 1'b1
  } lane_state_t;

  localparam logic NEG_PASS   = 1'b0;
  localparam logic NEG_NEGATE = 1'b1;

  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_negate_lane.sv
// One serial lane: SEEK/FLIP tracker, latched mode, result shift register and
// per-word flags that hold until the next word completes.
module serial_negate_lane
  import neg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_accept,
  input  logic             i_lsb,
  input  logic             i_msb,
  input  logic [CW-1:0]    i_pos,
  input  logic             i_neg,
  input  logic             i_din,
  output logic             o_y,
  output logic [WIDTH-1:0] o_word,
  output logic             o_ovf,
  output logic             o_zero
);

  lane_state_t      r_state;
  lane_state_t      w_state_cur;
  lane_state_t      w_state_next;
  logic             r_mode;
  logic             w_mode_cur;
  logic             w_y_bit;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_next;
  logic [WIDTH-1:0] r_word;
  logic             r_y;
  logic             r_ovf;
  logic             r_zero;

  // An LSB restarts the lane from SEEK with the freshly sampled mode, so the
  // current bit must already see those values rather than the registered ones.
  always_comb begin
    w_state_cur  = i_lsb ? SEEK : r_state;
    w_mode_cur   = i_lsb ? i_neg : r_mode;
    w_y_bit      = (w_state_cur == FLIP && w_mode_cur == NEG_NEGATE) ? ~i_din : i_din;
    w_state_next = (w_state_cur == SEEK && i_din) ? FLIP : w_state_cur;
    w_shift_next = i_lsb ? '0 : r_shift;
    w_shift_next[i_pos] = w_y_bit;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= SEEK;
      r_mode  <= NEG_PASS;
      r_shift <= '0;
      r_word  <= '0;
      r_y     <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else if (i_accept) begin
      r_state <= w_state_next;
      r_mode  <= w_mode_cur;
      r_shift <= w_shift_next;
      r_y     <= w_y_bit;
      if (i_msb) begin
        r_word <= w_shift_next;
        r_zero <= (w_state_next == SEEK);
        // First 1 landing on the MSB means the input was the most-negative value.
        r_ovf  <= (w_mode_cur == NEG_NEGATE) && (w_state_cur == SEEK) && i_din;
      end
    end
  end

  assign o_y    = r_y;
  assign o_word = r_word;
  assign o_ovf  = r_ovf;
  assign o_zero = r_zero;

endmodule

// File: rtl/serial_twos_negator.sv
// Multi-lane serial two's-complement negator with shared word framing,
// registered serial output, parallel result word and per-lane flags.
module serial_twos_negator
  import neg_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic                      t_clk,
  input  logic                      r_n,
  input  logic                      bit_valid,
  input  logic                      sof,
  input  logic [CHANNELS-1:0]       neg,
  input  logic [CHANNELS-1:0]       din,
  output logic [CHANNELS-1:0]       y,
  output logic                      y_valid,
  output logic [CHANNELS*WIDTH-1:0] word,
  output logic                      word_valid,
  output logic [CHANNELS-1:0]       ovf,
  output logic [CHANNELS-1:0]       zero,
  output logic                      sync_err
);

  localparam int CW = cnt_width(WIDTH);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_pos;
  logic [CW-1:0] w_cnt_next;
  logic          w_lsb;
  logic          w_msb;
  logic          w_abort;
  logic          r_y_valid;
  logic          r_word_valid;
  logic          r_sync_err;

  // sof forces the accepted bit to position 0; mid-word that aborts the word.
  always_comb begin
    w_pos      = sof ? '0 : r_cnt;
    w_lsb      = (w_pos == '0);
    w_msb      = (w_pos == CW'(WIDTH - 1));
    w_abort    = bit_valid && sof && (r_cnt != '0);
    w_cnt_next = w_msb ? '0 : (w_pos + CW'(1));
  end

  always_ff @(posedge t_clk or negedge r_n) begin
    if (!r_n) begin
      r_cnt        <= '0;
      r_y_valid    <= 1'b0;
      r_word_valid <= 1'b0;
      r_sync_err   <= 1'b0;
    end else begin
      if (bit_valid) begin
        r_cnt <= w_cnt_next;
      end
      r_y_valid    <= bit_valid;
      r_word_valid <= bit_valid && w_msb;
      r_sync_err   <= w_abort;
    end
  end

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
      serial_negate_lane #(
        .WIDTH (WIDTH),
        .CW    (CW)
      ) u_lane (
        .i_clk    (t_clk),
        .i_rst_n  (r_n),
        .i_accept (bit_valid),
        .i_lsb    (w_lsb),
        .i_msb    (w_msb),
        .i_pos    (w_pos),
        .i_neg    (neg[gi]),
        .i_din    (din[gi]),
        .o_y      (y[gi]),
        .o_word   (word[gi*WIDTH +: WIDTH]),
        .o_ovf    (ovf[gi]),
        .o_zero   (zero[gi])
      );
    end
  endgenerate

  assign y_valid    = r_y_valid;
  assign word_valid = r_word_valid;
  assign sync_err   = r_sync_err;

endmodule

// File: tb/tb_serial_twos_negator.sv
// Scoreboard bench: driver pushes arithmetic-model expectations, monitor pops
// and compares whenever the DUT presents a bit or a word.
module tb_serial_twos_negator;

  localparam int W  = 4;
  localparam int CH = 2;

  typedef struct packed {
    logic [CH-1:0] y;
    logic          abort;
  } ybit_t;

  typedef struct packed {
    logic [CH*W-1:0] word;
    logic [CH-1:0]   ovf;
    logic [CH-1:0]   zero;
  } wexp_t;

  logic            clk;
  logic            r_n;
  logic            bit_valid;
  logic            sof;
  logic [CH-1:0]   neg;
  logic [CH-1:0]   din;
  logic [CH-1:0]   y;
  logic            y_valid;
  logic [CH*W-1:0] word;
  logic            word_valid;
  logic [CH-1:0]   ovf;
  logic [CH-1:0]   zero;
  logic            sync_err;

  serial_twos_negator #(.WIDTH(W), .CHANNELS(CH)) dut (
    .t_clk      (clk),
    .r_n        (r_n),
    .bit_valid  (bit_valid),
    .sof        (sof),
    .neg        (neg),
    .din        (din),
    .y          (y),
    .y_valid    (y_valid),
    .word       (word),
    .word_valid (word_valid),
    .ovf        (ovf),
    .zero       (zero),
    .sync_err   (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  ybit_t yq[$];
  wexp_t wq[$];

  // Reference model state: position in word, accumulated input, latched mode.
  int            mpos = 0;
  logic [W-1:0]  mval [CH];
  logic          mneg [CH];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send_bit(input logic [CH-1:0] d, input logic [CH-1:0] n, input logic s);
    ybit_t        e;
    wexp_t        we;
    logic [W-1:0] res;
    e.abort = s && (mpos != 0);
    if (s) mpos = 0;
    we = '0;
    for (int k = 0; k < CH; k++) begin
      if (mpos == 0) begin
        mneg[k] = n[k];
        mval[k] = '0;
      end
      mval[k][mpos] = d[k];
      // Bits so far of -x equal the same bits of -(x truncated to those bits).
      res = mneg[k] ? (W'(0) - mval[k]) : mval[k];
      e.y[k] = res[mpos];
      we.word[k*W +: W] = res;
      we.ovf[k]  = mneg[k] && (mval[k] == (W'(1) << (W - 1)));
      we.zero[k] = (mval[k] == '0);
    end
    @(posedge clk);
    #1;
    bit_valid = 1'b1;
    din = d;
    neg = n;
    sof = s;
    yq.push_back(e);
    if (mpos == W - 1) wq.push_back(we);
    mpos = (mpos + 1) % W;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      bit_valid = 1'b0;
      sof = 1'b0;
      din = $urandom_range(0, 3);
    end
  endtask

  task automatic send_word(input logic [CH*W-1:0] vals, input logic [CH-1:0] n,
                           input logic first_sof, input int gap_at, input int gap_len);
    logic [CH-1:0] d;
    for (int i = 0; i < W; i++) begin
      if (i == gap_at) idle(gap_len);
      for (int k = 0; k < CH; k++) d[k] = vals[k*W + i];
      send_bit(d, n, first_sof && (i == 0));
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((yq.size() != 0 || wq.size() != 0) && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("drain_y_queue", 64'(yq.size()), 0);
    chk("drain_word_queue", 64'(wq.size()), 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_outputs"}, {y, y_valid, word, word_valid, ovf, zero, sync_err}, 0);
  endtask

  // Monitor
  ybit_t         me;
  wexp_t         mw;
  logic [CH-1:0] last_y;
  wexp_t         hold;

  initial begin
    last_y = '0;
    hold   = '0;
    forever begin
      @(negedge clk);
      if (!r_n) begin
        last_y = '0;
        hold   = '0;
      end else begin
        if (y_valid) begin
          if (yq.size() == 0) begin
            chk("unexpected_y_valid", 1, 0);
          end else begin
            me = yq.pop_front();
            chk("y", y, me.y);
            chk("sync_err", sync_err, me.abort);
            last_y = me.y;
          end
        end else begin
          chk("y_hold", y, last_y);
          chk("sync_err_idle", sync_err, 0);
        end
        if (word_valid) begin
          if (wq.size() == 0) begin
            chk("unexpected_word_valid", 1, 0);
          end else begin
            mw = wq.pop_front();
            chk("word", word, mw.word);
            chk("ovf", ovf, mw.ovf);
            chk("zero", zero, mw.zero);
            hold = mw;
            $display("word %h ovf %b zero %b at %0t", word, ovf, zero, $time);
          end
        end else begin
          chk("word_hold", {word, ovf, zero}, hold);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    r_n = 1'b0;
    bit_valid = 1'b0;
    sof = 1'b0;
    neg = '0;
    din = '0;
    #2;
    check_all_zero("reset");
    #20;
    r_n = 1'b1;

    // Lane0 negate 0110 -> 1010, lane1 pass 0011.
    send_word({4'b0011, 4'b0110}, 2'b01, 1'b1, -1, 0);
    idle(2);
    drain();
    chk("t1_word", word, {4'b0011, 4'b1010});

    // Most-negative value.
    send_word({4'b0101, 4'b1000}, 2'b01, 1'b0, -1, 0);
    idle(1);
    drain();
    chk("t2_word0", word[3:0], 4'b1000);
    chk("t2_ovf0", ovf[0], 1);
    chk("t2_zero0", zero[0], 0);

    // Zero then 0001.
    send_word({4'b1111, 4'b0000}, 2'b11, 1'b1, -1, 0);
    send_word({4'b0000, 4'b0001}, 2'b11, 1'b0, -1, 0);
    idle(1);
    drain();
    chk("t3_word0", word[3:0], 4'b1111);
    chk("t3_zero0", zero[0], 0);

    // Back-to-back, second word without sof, 3-cycle gap mid-word.
    send_word({4'b1001, 4'b0101}, 2'b01, 1'b1, -1, 0);
    send_word({4'b0110, 4'b0111}, 2'b01, 1'b0, 2, 3);
    idle(1);
    drain();
    chk("t4_word0", word[3:0], 4'b1001);

    // Abort with sof on bit 2.
    send_bit(2'b11, 2'b11, 1'b1);
    send_bit(2'b01, 2'b11, 1'b0);
    send_word({4'b0100, 4'b0010}, 2'b11, 1'b1, -1, 0);
    idle(1);
    drain();
    chk("t5_word0", word[3:0], 4'b1110);

    // Asynchronous reset mid-word.
    send_bit(2'b01, 2'b11, 1'b1);
    send_bit(2'b10, 2'b11, 1'b0);
    idle(1);
    drain();
    #3;
    r_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    yq.delete();
    wq.delete();
    mpos = 0;
    @(posedge clk);
    @(posedge clk);
    #3;
    r_n = 1'b1;
    send_word({4'b0000, 4'b0011}, 2'b01, 1'b0, -1, 0);
    idle(1);
    drain();
    chk("t6_word0", word[3:0], 4'b1101);

    // Randomized traffic with random gaps and occasional sof.
    repeat (400) begin
      if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
      send_bit(CH'($urandom), CH'($urandom), ($urandom_range(0, 9) == 0));
    end
    idle(2);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
